// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
// ID/EX control unit for the 5-stage pipeline. It decodes the ID opcode into
// the EX control bundle and registers it. It tracks in-flight destinations in a
// small scoreboard to detect RAW hazards, with or without forwarding. It honours
// branch flush and MEM back-pressure, and counts issued instructions and
// inserted bubbles.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   id_valid, id_opcode, id_src1,
//   id_src2, id_dest                instruction currently in ID
//   id_ready                        ID instruction consumed this cycle (comb)
//   hazard_stall                    freeze PC and IF/ID (comb)
//   mem_stall                       hold all pipeline state
//   flush                           kill ID instruction and EX entry
//   ex_*                            registered EX control bundle
//   perf_issued, perf_bubbles       wrapping performance counters
module pipe_ctrl_unit #(
  parameter int REG_AW    = 5,
  parameter int EXE_W     = 5,
  parameter int HAZ_DEPTH = 2,
  parameter int FWD_EN    = 1,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic [REG_AW-1:0] id_dest,
  output logic              id_ready,
  output logic              hazard_stall,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [EXE_W-1:0]  ex_cmd,
  output logic              ex_is_imm,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic              ex_wb_en,
  output logic              ex_st_or_bne,
  output logic              ex_br_bez,
  output logic              ex_br_bne,
  output logic              ex_jmp,
  output logic              ex_illegal,
  output logic [REG_AW-1:0] ex_dest,
  output logic [CNT_W-1:0]  perf_issued,
  output logic [CNT_W-1:0]  perf_bubbles
);

  typedef struct packed {
    logic              valid;
    logic [EXE_W-1:0]  cmd;
    logic              is_imm;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
    logic              st_or_bne;
    logic              br_bez;
    logic              br_bne;
    logic              jmp;
    logic              illegal;
    logic [REG_AW-1:0] dest;
  } bundle_t;

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_r;
    logic [REG_AW-1:0] dest;
  } sb_ent_t;

  bundle_t          ex_q, ex_d;
  bundle_t          dec;
  logic             dec_rd1, dec_rd2;
  sb_ent_t          sb_q [HAZ_DEPTH];
  sb_ent_t          sb_d [HAZ_DEPTH];
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] bubbles_q, bubbles_d;
  logic             raw_hit;

  // Opcode decode. Unknown opcodes still occupy a slot, as an illegal NOP.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.dest  = id_dest;
    dec_rd1   = 1'b0;
    dec_rd2   = 1'b0;
    case (id_opcode)
      6'd0: ;
      6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12: begin
        dec.wb_en = 1'b1;
        dec_rd1   = 1'b1;
        dec_rd2   = 1'b1;
        case (id_opcode)
          6'd3:    dec.cmd = EXE_W'(1);
          6'd5:    dec.cmd = EXE_W'(2);
          6'd6:    dec.cmd = EXE_W'(3);
          6'd7:    dec.cmd = EXE_W'(4);
          6'd8:    dec.cmd = EXE_W'(5);
          6'd9:    dec.cmd = EXE_W'(6);
          6'd10:   dec.cmd = EXE_W'(7);
          6'd11:   dec.cmd = EXE_W'(8);
          6'd12:   dec.cmd = EXE_W'(9);
          default: dec.cmd = EXE_W'(0);
        endcase
      end
      6'd32, 6'd33: begin
        dec.cmd    = (id_opcode == 6'd33) ? EXE_W'(1) : EXE_W'(0);
        dec.is_imm = 1'b1;
        dec.wb_en  = 1'b1;
        dec_rd1    = 1'b1;
      end
      6'd36: begin
        dec.is_imm   = 1'b1;
        dec.mem_r_en = 1'b1;
        dec.wb_en    = 1'b1;
        dec_rd1      = 1'b1;
      end
      6'd37: begin
        dec.is_imm    = 1'b1;
        dec.mem_w_en  = 1'b1;
        dec.st_or_bne = 1'b1;
        dec_rd1       = 1'b1;
        dec_rd2       = 1'b1;
      end
      6'd40: begin
        dec.br_bez = 1'b1;
        dec_rd1    = 1'b1;
      end
      6'd41: begin
        dec.br_bne    = 1'b1;
        dec.st_or_bne = 1'b1;
        dec_rd1       = 1'b1;
        dec_rd2       = 1'b1;
      end
      6'd42: dec.jmp = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  // RAW detection. With forwarding only a load sitting in EX (entry 0) can't
  // be bypassed; without it every in-flight writer blocks until it drops off.
  always_comb begin
    raw_hit = 1'b0;
    for (int k = 0; k < HAZ_DEPTH; k++) begin
      if ((FWD_EN == 0) || (k == 0)) begin
        if (sb_q[k].valid && (sb_q[k].dest != '0) &&
            ((FWD_EN != 0) ? sb_q[k].mem_r : sb_q[k].wb_en) &&
            ((dec_rd1 && (sb_q[k].dest == id_src1)) ||
             (dec_rd2 && (sb_q[k].dest == id_src2)))) begin
          raw_hit = 1'b1;
        end
      end
    end
  end

  assign hazard_stall = id_valid && !flush && raw_hit;

  // Next-state: flush beats mem_stall for the EX slot only; older scoreboard
  // entries advance whenever MEM is not stalling.
  always_comb begin
    ex_d      = ex_q;
    issued_d  = issued_q;
    bubbles_d = bubbles_q;
    id_ready  = 1'b0;
    sb_d      = sb_q;
    if (flush) begin
      ex_d     = '0;
      id_ready = 1'b1;
    end else if (mem_stall) begin
      ex_d = ex_q;
    end else if (hazard_stall) begin
      ex_d      = '0;
      bubbles_d = bubbles_q + CNT_W'(1);
    end else if (id_valid) begin
      ex_d     = dec;
      id_ready = 1'b1;
      issued_d = issued_q + CNT_W'(1);
    end else begin
      ex_d = '0;
    end
    if (!mem_stall) begin
      for (int k = 1; k < HAZ_DEPTH; k++) begin
        sb_d[k] = sb_q[k-1];
      end
    end
    sb_d[0] = '{valid: ex_d.valid, wb_en: ex_d.wb_en, mem_r: ex_d.mem_r_en, dest: ex_d.dest};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      issued_q  <= '0;
      bubbles_q <= '0;
      for (int k = 0; k < HAZ_DEPTH; k++) begin
        sb_q[k] <= '0;
      end
    end else begin
      ex_q      <= ex_d;
      issued_q  <= issued_d;
      bubbles_q <= bubbles_d;
      for (int k = 0; k < HAZ_DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_cmd       = ex_q.cmd;
  assign ex_is_imm    = ex_q.is_imm;
  assign ex_mem_r_en  = ex_q.mem_r_en;
  assign ex_mem_w_en  = ex_q.mem_w_en;
  assign ex_wb_en     = ex_q.wb_en;
  assign ex_st_or_bne = ex_q.st_or_bne;
  assign ex_br_bez    = ex_q.br_bez;
  assign ex_br_bne    = ex_q.br_bne;
  assign ex_jmp       = ex_q.jmp;
  assign ex_illegal   = ex_q.illegal;
  assign ex_dest      = ex_q.dest;
  assign perf_issued  = issued_q;
  assign perf_bubbles = bubbles_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Two instances share one stimulus stream: instance A has forwarding (4-bit
// counters, so wrap-around is exercised), instance B has none. Each one is
// compared against an instruction-history model built from the decode table and
// the hazard and priority rules.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
  logic       mem_stall = 1'b0, flush = 1'b0;

  logic       a_rdy, a_haz, a_v, a_imm, a_mr, a_mw, a_wb, a_sob, a_bez, a_bne, a_jmp, a_ill;
  logic [4:0] a_cmd, a_dest;
  logic [3:0] a_iss, a_bub;
  logic       b_rdy, b_haz, b_v, b_imm, b_mr, b_mw, b_wb, b_sob, b_bez, b_bne, b_jmp, b_ill;
  logic [4:0] b_cmd, b_dest;
  logic [7:0] b_iss, b_bub;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.REG_AW(5), .EXE_W(5), .HAZ_DEPTH(2), .FWD_EN(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
    .id_ready(a_rdy), .hazard_stall(a_haz), .mem_stall(mem_stall), .flush(flush),
    .ex_valid(a_v), .ex_cmd(a_cmd), .ex_is_imm(a_imm), .ex_mem_r_en(a_mr),
    .ex_mem_w_en(a_mw), .ex_wb_en(a_wb), .ex_st_or_bne(a_sob), .ex_br_bez(a_bez),
    .ex_br_bne(a_bne), .ex_jmp(a_jmp), .ex_illegal(a_ill), .ex_dest(a_dest),
    .perf_issued(a_iss), .perf_bubbles(a_bub));

  pipe_ctrl_unit #(.REG_AW(5), .EXE_W(5), .HAZ_DEPTH(2), .FWD_EN(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
    .id_ready(b_rdy), .hazard_stall(b_haz), .mem_stall(mem_stall), .flush(flush),
    .ex_valid(b_v), .ex_cmd(b_cmd), .ex_is_imm(b_imm), .ex_mem_r_en(b_mr),
    .ex_mem_w_en(b_mw), .ex_wb_en(b_wb), .ex_st_or_bne(b_sob), .ex_br_bez(b_bez),
    .ex_br_bne(b_bne), .ex_jmp(b_jmp), .ex_illegal(b_ill), .ex_dest(b_dest),
    .perf_issued(b_iss), .perf_bubbles(b_bub));

  typedef struct packed {
    logic       valid;
    logic [4:0] cmd;
    logic       imm, mr, mw, wb, sob, bez, bne, jmp, ill;
    logic [4:0] dest;
    logic       rd1, rd2;
  } ins_t;

  // Model state: the instructions currently in flight, newest first.
  ins_t hist [2][2];
  int   iss [2];
  int   bub [2];
  int   fwd_p [2] = '{1, 0};
  int   cw_p  [2] = '{4, 8};
  int   errs = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t decode(input logic [5:0] op, input logic [4:0] d);
    ins_t r;
    int   alu_ops [10] = '{1, 3, 5, 6, 7, 8, 9, 10, 11, 12};
    r = '0;
    r.valid = 1'b1;
    r.dest  = d;
    for (int k = 0; k < 10; k++) begin
      if (op == 6'(alu_ops[k])) begin
        r.cmd = 5'(k); r.wb = 1; r.rd1 = 1; r.rd2 = 1;
        return r;
      end
    end
    case (op)
      6'd0:  ;
      6'd32: begin r.imm = 1; r.wb = 1; r.rd1 = 1; end
      6'd33: begin r.cmd = 5'd1; r.imm = 1; r.wb = 1; r.rd1 = 1; end
      6'd36: begin r.imm = 1; r.mr = 1; r.wb = 1; r.rd1 = 1; end
      6'd37: begin r.imm = 1; r.mw = 1; r.sob = 1; r.rd1 = 1; r.rd2 = 1; end
      6'd40: begin r.bez = 1; r.rd1 = 1; end
      6'd41: begin r.bne = 1; r.sob = 1; r.rd1 = 1; r.rd2 = 1; end
      6'd42: r.jmp = 1;
      default: r.ill = 1;
    endcase
    return r;
  endfunction

  function automatic logic [19:0] pack(input ins_t e);
    return {e.valid, e.cmd, e.imm, e.mr, e.mw, e.wb, e.sob, e.bez, e.bne, e.jmp, e.ill, e.dest};
  endfunction

  function automatic bit model_haz(input int i, input ins_t d);
    bit h = 0;
    if (!id_valid || flush) return 0;
    for (int k = 0; k < 2; k++) begin
      ins_t p = hist[i][k];
      bit   producer = (fwd_p[i] != 0) ? (k == 0 && p.valid && p.mr) : (p.valid && p.wb);
      if (producer && p.dest != 0 &&
          ((d.rd1 && p.dest == id_src1) || (d.rd2 && p.dest == id_src2))) h = 1;
    end
    return h;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      iss[i] = 0; bub[i] = 0;
      for (int k = 0; k < 2; k++) hist[i][k] = '0;
    end
  endtask

  task automatic check_regs(input string when);
    check({when, " A bundle"}, 32'(pack_dut_a()), 32'(pack(hist[0][0])));
    check({when, " B bundle"}, 32'(pack_dut_b()), 32'(pack(hist[1][0])));
    check({when, " A issued"}, 32'(a_iss), 32'(iss[0] % (1 << cw_p[0])));
    check({when, " A bubbles"}, 32'(a_bub), 32'(bub[0] % (1 << cw_p[0])));
    check({when, " B issued"}, 32'(b_iss), 32'(iss[1] % (1 << cw_p[1])));
    check({when, " B bubbles"}, 32'(b_bub), 32'(bub[1] % (1 << cw_p[1])));
  endtask

  function automatic logic [19:0] pack_dut_a();
    return {a_v, a_cmd, a_imm, a_mr, a_mw, a_wb, a_sob, a_bez, a_bne, a_jmp, a_ill, a_dest};
  endfunction
  function automatic logic [19:0] pack_dut_b();
    return {b_v, b_cmd, b_imm, b_mr, b_mw, b_wb, b_sob, b_bez, b_bne, b_jmp, b_ill, b_dest};
  endfunction

  // One transaction: called at a negedge, drives ID, checks the combinational
  // outputs, then checks the registered bundle after the edge; ends at a negedge.
  task automatic cycle(input int v, input int op, input int s1, input int s2,
                       input int d, input int ms, input int fl);
    ins_t dec;
    bit   haz [2];
    bit   rdy [2];
    id_valid = 1'(v); id_opcode = 6'(op); id_src1 = 5'(s1); id_src2 = 5'(s2);
    id_dest = 5'(d); mem_stall = 1'(ms); flush = 1'(fl);
    #1;
    dec = decode(id_opcode, id_dest);
    for (int i = 0; i < 2; i++) begin
      haz[i] = model_haz(i, dec);
      rdy[i] = fl ? 1 : ms ? 0 : haz[i] ? 0 : id_valid;
    end
    check("A hazard_stall", 32'(a_haz), 32'(haz[0]));
    check("A id_ready", 32'(a_rdy), 32'(rdy[0]));
    check("B hazard_stall", 32'(b_haz), 32'(haz[1]));
    check("B id_ready", 32'(b_rdy), 32'(rdy[1]));
    $display("txn v=%0d op=%0d s1=%0d s2=%0d d=%0d ms=%0d fl=%0d hazA=%0d hazB=%0d",
             v, op, s1, s2, d, ms, fl, a_haz, b_haz);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (fl) begin
        if (!ms) hist[i][1] = hist[i][0];
        hist[i][0] = '0;
      end else if (!ms) begin
        hist[i][1] = hist[i][0];
        if (haz[i]) begin hist[i][0] = '0; bub[i]++; end
        else if (v != 0) begin hist[i][0] = dec; iss[i]++; end
        else hist[i][0] = '0;
      end
    end
    check_regs("post-edge");
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_regs("async reset");
    $display("txn async reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int op_tab [16] = '{0, 1, 3, 5, 8, 12, 32, 33, 36, 36, 37, 40, 41, 42, 36, 63};

  initial begin
    model_clear();
    id_valid = 1'b1; id_opcode = 6'd1; id_dest = 5'd2; id_src1 = 5'd1; id_src2 = 5'd1;
    @(negedge clk);
    @(negedge clk);
    check_regs("in reset");
    check("reset A id_ready", 32'(a_rdy), 32'd1);
    check("reset B hazard_stall", 32'(b_haz), 32'd0);
    rst_n = 1'b1;
    // first edge after release issues the ADD
    cycle(1, 1, 1, 1, 2, 0, 0);
    check("first ADD ex_wb_en", 32'(a_wb), 32'd1);
    // load-use: LD r3, ADD r4,r3,r5 (stalls once on A, twice on B)
    cycle(1, 36, 1, 0, 3, 0, 0);
    repeat (3) cycle(1, 1, 3, 5, 4, 0, 0);
    // RAW through ADDI r7 then SUB r1,r7,r2; and producer r0
    cycle(1, 32, 1, 0, 7, 0, 0);
    repeat (3) cycle(1, 3, 7, 2, 1, 0, 0);
    cycle(1, 32, 1, 0, 0, 0, 0);
    cycle(1, 3, 0, 2, 1, 0, 0);
    // flush during a load-use stall
    cycle(1, 36, 1, 0, 3, 0, 0);
    cycle(1, 1, 3, 5, 4, 0, 1);
    check("flush leaves A ex_valid low", 32'(a_v), 32'd0);
    // MEM back-pressure with ST in EX
    cycle(1, 37, 1, 2, 0, 0, 0);
    repeat (3) cycle(1, 1, 1, 2, 6, 1, 0);
    cycle(1, 1, 1, 2, 6, 0, 0);
    // flush and mem_stall together
    cycle(1, 1, 1, 2, 6, 1, 1);
    // illegal opcode
    cycle(1, 63, 1, 2, 3, 0, 0);
    check("opcode 63 ex_illegal", 32'(a_ill), 32'd1);
    // reset while a load-use stall is pending
    cycle(1, 36, 1, 0, 3, 0, 0);
    async_reset();
    cycle(1, 1, 3, 5, 4, 0, 0);
    // randomized traffic over a small register set to keep hazards frequent
    for (int n = 0; n < 1500; n++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : op_tab[$urandom_range(0, 15)];
      cycle(($urandom_range(0, 5) != 0), op, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 299) == 0) async_reset();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Registered, parametrised control unit for the 5-stage pipeline, sitting at the ID/EX boundary.
- Decodes the ID-stage opcode into the EX control bundle and holds it in the ID/EX control register.
- Tracks in-flight destination registers to detect data hazards, then stalls IF/ID and inserts bubbles, with or without forwarding.
- Honours branch flush and back-pressure from MEM.
- Keeps issue and bubble performance counters.

## Interface
Parameters:
- REG_AW, 5: register-address width.
- EXE_W, 5: exec_cmd width (must be ≥4).
- HAZ_DEPTH, 2: in-flight stages checked for hazards (EX..), 1–4.
- FWD_EN, 1: 1 = forwarding exists (stall only on load-use); 0 = stall on any RAW.
- CNT_W, 32: performance-counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds an instruction
- id_opcode  in  6  instruction opcode
- id_src1, id_src2, id_dest  in  REG_AW each  register addresses
- id_ready  out  1  instruction consumed this cycle
- hazard_stall  out  1  combinational; freeze PC and IF/ID
- mem_stall  in  1  MEM back-pressure; hold all pipeline state
- flush  in  1  branch taken in EX; kill ID instruction and EX entry
- ex_valid  out  1  registered bundle holds a real instruction
- ex_cmd  out  EXE_W  ALU command
- ex_is_imm, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_st_or_bne, ex_br_bez, ex_br_bne, ex_jmp, ex_illegal  out  1 each
- ex_dest  out  REG_AW  destination
- perf_issued, perf_bubbles  out  CNT_W  counters

## Operation
Decode map: opcode → cmd, then flags.
- 0 NOP: no flags.
- 1 ADD → 0; 3 SUB → 1; 5 AND → 2; 6 OR → 3; 7 NOR → 4; 8 XOR → 5; 9 SLA → 6; 10 SLL → 7; 11 SRA → 8; 12 SRL → 9. All: wb_en; read src1 and src2.
- 32 ADDI → 0; 33 SUBI → 1. Both: is_imm, wb_en; read src1.
- 36 LD → 0: is_imm, mem_r_en, wb_en; read src1.
- 37 ST → 0: is_imm, mem_w_en, st_or_bne; read src1 and src2.
- 40 BEZ → 0: br_bez; read src1.
- 41 BNE → 0: br_bne, st_or_bne; read src1 and src2.
- 42 JMP → 0: jmp; reads nothing.
- Any other opcode: decoded as NOP with ex_illegal=1.

Scoreboard:
- HAZ_DEPTH entries of {valid, wb_en, mem_r, dest}. Entry 0 mirrors the ex_* register.
- Shifts toward higher entries on every cycle with mem_stall=0. The oldest entry drops off.

Hazard rule (active when id_valid=1 and flush=0):
- FWD_EN=0: stall if any valid entry has wb_en=1, dest≠0, and dest equals a source the decoded instruction reads.
- FWD_EN=1: stall only if entry 0 has mem_r=1 and the same address match holds.
- Register 0 never causes a hazard.

Per-cycle priority:
1. flush: ex register and entry 0 load a bubble; id_ready=1 (ID instruction discarded, not counted). Entries ≥1 shift normally, or hold if mem_stall=1.
2. mem_stall: all state holds; id_ready=0.
3. hazard_stall: bubble loaded into EX; id_ready=0; perf_bubbles+1.
4. id_valid: decoded bundle loaded; id_ready=1; perf_issued+1.
5. Otherwise: bubble loaded; no counter change.

Other rules:
- A bubble loads all ex_* outputs as 0.
- hazard_stall is forced to 0 when flush=1 or id_valid=0.
- Counters wrap at 2^CNT_W.

## Timing
- Reset (rst_n low, asynchronous): all ex_* outputs 0, scoreboard cleared, counters 0. id_ready and hazard_stall then follow their combinational rules. Reset mid-stall drops the stalled state entirely.
- Decode latency: 1 cycle. Bundle visible the cycle after id_ready=1.
- hazard_stall and id_ready are combinational from current inputs and scoreboard, with no added latency.
- Load-use with FWD_EN=1 costs exactly 1 bubble. RAW with FWD_EN=0 costs HAZ_DEPTH−k bubbles when the producer sits in entry k.
- flush and mem_stall in the same cycle: flush wins for entry 0; entries ≥1 hold.

## Test plan
- Reset with id_valid=1, opcode=1 → all ex_* 0 and counters 0 during reset. First edge after release gives ex_valid=1, ex_cmd=0, ex_wb_en=1.
- FWD_EN=1: LD r3, then ADD r4,r3,r5 on the next cycle → hazard_stall=1 for one cycle, one bubble, perf_bubbles=1, ADD issues the cycle after.
- FWD_EN=0, HAZ_DEPTH=2: ADDI r7, then SUB r1,r7,r2 → two stall cycles. Same sequence with r0 as producer dest → no stall.
- flush during a load-use stall → ID instruction discarded, ex_valid=0 next cycle, perf_issued unchanged, hazard_stall=0.
- mem_stall high 3 cycles with a valid ST in EX → ex_* and scoreboard constant, id_ready=0. Release → normal advance.
- Opcode 63 → ex_illegal=1, ex_valid=1, all other flags 0. perf_issued wraps from 2^CNT_W−1 to 0 with CNT_W=4.
